// File: rtl/fetch_predict_unit.sv
// fetch_predict_unit
//   Instruction-fetch PC register with a tagged direct-mapped BTB and a BHT
//   of saturating counters. The next PC is chosen from these sources:
//   mispredict redirect, rollback, stall hold, predicted target, or pc+4.
//
//   Ports:
//     clk, rst             clock, synchronous active-low reset
//     pc_write             1 = PC may advance, 0 = hold (load-use stall)
//     rollback             step PC back one instruction (double-issue flush)
//     mem_valid            MEM stage holds a resolved branch/jump
//     mem_pc/mem_taken/mem_target         resolved instruction and outcome
//     mem_pred_taken/mem_pred_target      prediction carried with it
//     pc, pc_plus4         current fetch PC and its successor
//     pred_taken, pred_target, btb_hit    fetch-stage prediction for pc
//     mispredict           combinational flush request
//
//   Optional macro FETCH_PERF_CNT_EN adds perf_branches and perf_mispredicts
//   (32-bit wrapping event counters).
module fetch_predict_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BTB_IDX_W = 8,
    parameter int              BTB_TAG_W = 8,
    parameter int              BHT_IDX_W = 8,
    parameter int              CNT_W     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            rollback,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_pc,
    input  logic            mem_taken,
    input  logic [XLEN-1:0] mem_target,
    input  logic            mem_pred_taken,
    input  logic [XLEN-1:0] mem_pred_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic            btb_hit,
    output logic            mispredict
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
`endif
);

    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int BHT_N = 1 << BHT_IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    // Weakly not-taken: 2^(CNT_W-1)-1, which is 0 for a 1-bit counter.
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'((1 << (CNT_W - 1)) - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    logic                 btb_valid  [BTB_N];
    logic [BTB_TAG_W-1:0] btb_tag    [BTB_N];
    logic [XLEN-1:0]      btb_target [BTB_N];
    logic [CNT_W-1:0]     bht_cnt    [BHT_N];

    logic [BTB_IDX_W-1:0] f_btb_idx, m_btb_idx;
    logic [BTB_TAG_W-1:0] f_tag, m_tag;
    logic [BHT_IDX_W-1:0] f_bht_idx, m_bht_idx;
    logic [XLEN-1:0]      pc_next;

    assign f_btb_idx = pc[BTB_IDX_W+1:2];
    assign f_tag     = pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
    assign f_bht_idx = pc[BHT_IDX_W+1:2];
    assign m_btb_idx = mem_pc[BTB_IDX_W+1:2];
    assign m_tag     = mem_pc[BTB_IDX_W+BTB_TAG_W+1:BTB_IDX_W+2];
    assign m_bht_idx = mem_pc[BHT_IDX_W+1:2];

    // Fetch-side lookup: tables are read asynchronously, so an update landing
    // on the same entry this cycle is only seen after the clock edge.
    assign btb_hit     = btb_valid[f_btb_idx] && (btb_tag[f_btb_idx] == f_tag);
    assign pred_taken  = btb_hit && bht_cnt[f_bht_idx][CNT_W-1];
    assign pred_target = btb_hit ? btb_target[f_btb_idx] : '0;
    assign pc_plus4    = pc + XLEN'(4);

    // A taken branch with the right direction can still go to a wrong target.
    assign mispredict = mem_valid &&
                        ((mem_taken != mem_pred_taken) ||
                         (mem_taken && (mem_target != mem_pred_target)));

    always_comb begin
        pc_next = pc_plus4;
        if (mispredict)
            pc_next = mem_taken ? mem_target : mem_pc + XLEN'(4);
        else if (rollback)
            pc_next = pc - XLEN'(4);
        else if (!pc_write)
            pc_next = pc;
        else if (pred_taken)
            pc_next = pred_target;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            pc <= RESET_PC;
        else
            pc <= pc_next;
    end

    // Control state: valid bits and counters are cleared by reset, which also
    // discards any update presented in the reset cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BTB_N; i++) btb_valid[i] <= 1'b0;
            for (int i = 0; i < BHT_N; i++) bht_cnt[i] <= CNT_RST;
        end else if (mem_valid) begin
            bht_cnt[m_bht_idx] <= mem_taken ? sat_inc(bht_cnt[m_bht_idx])
                                            : sat_dec(bht_cnt[m_bht_idx]);
            if (mem_taken)
                btb_valid[m_btb_idx] <= 1'b1;
        end
    end

    // Data payload of the BTB; only meaningful behind a set valid bit.
    always_ff @(posedge clk) begin
        if (mem_valid && mem_taken) begin
            btb_tag[m_btb_idx]    <= m_tag;
            btb_target[m_btb_idx] <= mem_target;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (mem_valid)  perf_branches    <= perf_branches + 32'd1;
            if (mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_predict_unit.sv
module tb_fetch_predict_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic        rollback;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_taken;
    logic [31:0] mem_target;
    logic        mem_pred_taken;
    logic [31:0] mem_pred_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        btb_hit;
    logic        mispredict;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_predict_unit #(
        .XLEN(32), .RESET_PC(32'h0000_0100),
        .BTB_IDX_W(8), .BTB_TAG_W(8), .BHT_IDX_W(8), .CNT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .rollback(rollback),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_taken(mem_taken),
        .mem_target(mem_target), .mem_pred_taken(mem_pred_taken),
        .mem_pred_target(mem_pred_target),
        .pc(pc), .pc_plus4(pc_plus4), .pred_taken(pred_taken),
        .pred_target(pred_target), .btb_hit(btb_hit), .mispredict(mispredict)
`ifdef FETCH_PERF_CNT_EN
        , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_valid = 1'b0; mem_pc = '0; mem_taken = 1'b0; mem_target = '0;
        mem_pred_taken = 1'b0; mem_pred_target = '0;
        #1;
    endtask

    task automatic branch(input logic [31:0] bpc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
        mem_valid = 1'b1; mem_pc = bpc; mem_taken = tk; mem_target = tgt;
        mem_pred_taken = ptk; mem_pred_target = ptgt;
        #1;
    endtask

    // Steer pc to addr via a not-taken mispredict of addr-4 (no BTB write).
    task automatic redirect(input logic [31:0] addr);
        branch(addr - 32'd4, 1'b0, 32'h0, 1'b1, 32'h0);
        step();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; pc_write = 1'b1; rollback = 1'b0;
        idle();
        step(); step();
        chk("rst_pc",   pc, 32'h100);
        chk("rst_pred", 32'(pred_taken), 32'd0);
        chk("rst_hit",  32'(btb_hit), 32'd0);
        chk("rst_tgt",  pred_target, 32'd0);
        chk("rst_mis",  32'(mispredict), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf", perf_branches, 32'd0);
`endif

        // Sequential fetch
        rst = 1'b1;
        step(); chk("seq_104", pc, 32'h104);
        step(); chk("seq_108", pc, 32'h108);
        chk("seq_pred", 32'(pred_taken), 32'd0);
        step(); chk("seq_10c", pc, 32'h10C);
        chk("seq_p4", pc_plus4, 32'h110);

        // Taken branch, predicted not-taken
        branch(32'h108, 1'b1, 32'h40, 1'b0, 32'h0);
        chk("tk_mis", 32'(mispredict), 32'd1);
        step(); idle();
        chk("tk_pc", pc, 32'h40);
        redirect(32'h108);
        chk("tk_hit",  32'(btb_hit), 32'd1);
        chk("tk_pred", 32'(pred_taken), 32'd1);
        chk("tk_tgt",  pred_target, 32'h40);
        step();
        chk("tk_jump", pc, 32'h40);

        // Two not-taken resolutions: counter 2 -> 1 -> 0
        branch(32'h108, 1'b0, 32'h0, 1'b1, 32'h40);
        chk("nt1_mis", 32'(mispredict), 32'd1);
        step(); chk("nt1_pc", pc, 32'h10C);
        chk("nt2_mis", 32'(mispredict), 32'd1);
        step(); idle();
        chk("nt2_pc", pc, 32'h10C);
        redirect(32'h108);
        chk("nt_hit",  32'(btb_hit), 32'd1);
        chk("nt_pred", 32'(pred_taken), 32'd0);
        step();
        chk("nt_seq", pc, 32'h10C);

        // Stall, then mispredict overriding the stall
        redirect(32'h200);
        pc_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk("stall_hold", pc, 32'h200);
        end
        branch(32'h600, 1'b1, 32'h300, 1'b0, 32'h0);
        step(); idle();
        chk("stall_mis", pc, 32'h300);
        pc_write = 1'b1;

        // Rollback, then rollback with mispredict
        redirect(32'h210);
        rollback = 1'b1;
        step(); rollback = 1'b0;
        chk("rb_pc", pc, 32'h20C);
        rollback = 1'b1;
        branch(32'h400, 1'b0, 32'h0, 1'b1, 32'h0);
        step(); rollback = 1'b0; idle();
        chk("rb_mis", pc, 32'h404);

        // Five correctly predicted taken resolutions: counter saturates at 3
        branch(32'h108, 1'b1, 32'h40, 1'b1, 32'h40);
        chk("sat_mis", 32'(mispredict), 32'd0);
        for (int i = 0; i < 5; i++) step();
        idle();
        chk("sat_seq", pc, 32'h418);
        redirect(32'h108);
        chk("sat_pred", 32'(pred_taken), 32'd1);

        // Collision: update 0x108 target while fetching 0x108 (held by stall)
        pc_write = 1'b0;
        branch(32'h108, 1'b1, 32'h80, 1'b1, 32'h80);
        chk("col_mis", 32'(mispredict), 32'd0);
        chk("col_old", pred_target, 32'h40);
        step(); idle();
        chk("col_pc",  pc, 32'h108);
        chk("col_new", pred_target, 32'h80);
        pc_write = 1'b1;
        step();
        chk("col_jump", pc, 32'h80);

        // One not-taken from saturation leaves the counter taken (3 -> 2)
        branch(32'h108, 1'b0, 32'h0, 1'b1, 32'h80);
        step(); idle();
        redirect(32'h108);
        chk("sat_keep", 32'(pred_taken), 32'd1);

        // Wrap-around of pc+4 and pc-4
        branch(32'h800, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        step(); idle();
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_p4", pc_plus4, 32'h0);
        step();
        chk("wrap_inc", pc, 32'h0);
        rollback = 1'b1;
        step(); rollback = 1'b0;
        chk("wrap_dec", pc, 32'hFFFF_FFFC);

        // Reset mid-operation discards the concurrent update
        rst = 1'b0;
        branch(32'h100, 1'b1, 32'h50, 1'b0, 32'h0);
        step(); idle();
        rst = 1'b1; #1;
        chk("mrst_pc",   pc, 32'h100);
        chk("mrst_hit",  32'(btb_hit), 32'd0);
        chk("mrst_pred", 32'(pred_taken), 32'd0);
        redirect(32'h108);
        chk("mrst_hit108", 32'(btb_hit), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
